// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshaking.
// Stage 1 registers bit and group propagate/generate terms; stage 2 resolves carries and registers the result.
module cla_addsub_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GROUP = 4,
  localparam int unsigned NG = WIDTH / GROUP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero,
  output logic [NG-1:0]    o_P,
  output logic [NG-1:0]    o_G
);

  if ((WIDTH % GROUP) != 0 || WIDTH < 4 || GROUP == 0) begin : g_param_check
    $error("cla_addsub_pipe: WIDTH must be a multiple of GROUP and at least 4");
  end

  logic s1_load;
  logic s2_load;

  // Stage 1 operand preparation
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_c;
  logic [WIDTH-1:0] g_c;
  logic             c0_c;
  logic [NG-1:0]    gp_c;
  logic [NG-1:0]    gg_c;

  // Stage 1 registers
  logic             s1_valid;
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  logic             s1_c0;
  logic [NG-1:0]    s1_gp;
  logic [NG-1:0]    s1_gg;

  // Stage 2 carry resolution
  logic [NG-1:0]    grp_cin_c;
  logic [WIDTH-1:0] bit_cin_c;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovf_c;

  assign s2_load = !o_valid || i_ready;
  assign s1_load = !s1_valid || s2_load;
  assign o_ready = s1_load;

  // Bit and group propagate/generate of the effective operands
  always_comb begin
    logic gen;
    logic prop;
    gen   = 1'b0;
    prop  = 1'b1;
    b_eff = i_sub ? ~i_b : i_b;
    p_c   = i_a ^ b_eff;
    g_c   = i_a & b_eff;
    c0_c  = i_cin ^ i_sub;
    gp_c  = '0;
    gg_c  = '0;
    for (int k = 0; k < NG; k++) begin
      gen  = 1'b0;
      prop = 1'b1;
      for (int j = 0; j < GROUP; j++) begin
        gen  = g_c[k*GROUP + j] | (p_c[k*GROUP + j] & gen);
        prop = prop & p_c[k*GROUP + j];
      end
      gp_c[k] = prop;
      gg_c[k] = gen;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_c0    <= 1'b0;
      s1_gp    <= '0;
      s1_gg    <= '0;
    end else if (s1_load) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_p  <= p_c;
        s1_g  <= g_c;
        s1_c0 <= c0_c;
        s1_gp <= gp_c;
        s1_gg <= gg_c;
      end
    end
  end

  // Group carries by lookahead, then ripple within each group from its group carry
  always_comb begin
    logic gc;
    logic bc;
    gc        = s1_c0;
    bc        = 1'b0;
    grp_cin_c = '0;
    bit_cin_c = '0;
    for (int k = 0; k < NG; k++) begin
      grp_cin_c[k] = gc;
      gc = s1_gg[k] | (s1_gp[k] & gc);
    end
    for (int k = 0; k < NG; k++) begin
      bc = grp_cin_c[k];
      for (int j = 0; j < GROUP; j++) begin
        bit_cin_c[k*GROUP + j] = bc;
        bc = s1_g[k*GROUP + j] | (s1_p[k*GROUP + j] & bc);
      end
    end
    cout_c = gc;
    sum_c  = s1_p ^ bit_cin_c;
    ovf_c  = bit_cin_c[WIDTH-1] ^ gc;
  end

  // Result registers hold their value whenever no new beat moves in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_cout  <= 1'b0;
      o_ovf   <= 1'b0;
      o_zero  <= 1'b0;
      o_P     <= '0;
      o_G     <= '0;
    end else if (s2_load) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_sum  <= sum_c;
        o_cout <= cout_c;
        o_ovf  <= ovf_c;
        o_zero <= ~|sum_c;
        o_P    <= s1_gp;
        o_G    <= s1_gg;
      end
    end
  end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe: directed corner cases, backpressure, mid-flight reset
// and randomized traffic compared against an arithmetic reference model through a scoreboard queue.
module tb_cla_addsub_pipe;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned GROUP = 4;
  localparam int unsigned NG    = WIDTH / GROUP;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_sub;
  logic             i_cin;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic             o_ovf;
  logic             o_zero;
  logic [NG-1:0]    o_P;
  logic [NG-1:0]    o_G;

  cla_addsub_pipe #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_sub(i_sub), .i_cin(i_cin),
    .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum), .o_cout(o_cout),
    .o_ovf(o_ovf), .o_zero(o_zero), .o_P(o_P), .o_G(o_G)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic [NG-1:0]    p;
    logic [NG-1:0]    g;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          popped = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] snap_sum;
  logic [18:0] snap_flags;

  // Reference: plain integer arithmetic on the operands, groups judged by nibble sums
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic cin);
    exp_t            e;
    longint unsigned ua, ub, full;
    longint          sa, sb, r;
    logic [31:0]     bp;
    int              ag, bg;
    ua = 64'(a);
    ub = 64'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      full   = ua - ub - 64'(cin);
      r      = sa - sb - longint'(cin);
      e.cout = (ua >= ub + 64'(cin));
    end else begin
      full   = ua + ub + 64'(cin);
      r      = sa + sb + longint'(cin);
      e.cout = full[32];
    end
    e.sum  = full[31:0];
    e.ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.zero = (e.sum == 32'd0);
    bp = sub ? ~b : b;
    for (int k = 0; k < 8; k++) begin
      ag = int'(a[4*k +: 4]);
      bg = int'(bp[4*k +: 4]);
      e.g[k] = ((ag + bg) > 15);
      e.p[k] = ((ag ^ bg) == 15);
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then advance past the rising edge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (stall_prev) begin
      check("hold_sum", 64'(o_sum), 64'(snap_sum));
      check("hold_flags", 64'({o_cout, o_ovf, o_zero, o_P, o_G}), 64'(snap_flags));
    end
    if (o_valid && i_ready) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 64'(o_valid), 64'(0));
      end else begin
        e = q.pop_front();
        popped++;
        check("sum", 64'(o_sum), 64'(e.sum));
        check("cout", 64'(o_cout), 64'(e.cout));
        check("ovf", 64'(o_ovf), 64'(e.ovf));
        check("zero", 64'(o_zero), 64'(e.zero));
        check("grp_p", 64'(o_P), 64'(e.p));
        check("grp_g", 64'(o_G), 64'(e.g));
      end
    end
    if (i_valid && o_ready) q.push_back(model(i_a, i_b, i_sub, i_cin));
    stall_prev = o_valid && !i_ready;
    snap_sum   = o_sum;
    snap_flags = {o_cout, o_ovf, o_zero, o_P, o_G};
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic cin);
    i_valid = v;
    i_a     = a;
    i_b     = b;
    i_sub   = sub;
    i_cin   = cin;
  endtask

  // Single beat into an empty pipeline with i_ready high; result must appear two edges later
  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic cin,
                          input logic [31:0] exp_sum, input logic [2:0] exp_flags);
    i_ready = 1'b1;
    drive(1'b1, a, b, sub, cin);
    tick();
    i_valid = 1'b0;
    check({tag, "_lat1_valid"}, 64'(o_valid), 64'(0));
    tick();
    check({tag, "_lat2_valid"}, 64'(o_valid), 64'(1));
    check({tag, "_sum"}, 64'(o_sum), 64'(exp_sum));
    check({tag, "_cout_ovf_zero"}, 64'({o_cout, o_ovf, o_zero}), 64'(exp_flags));
    tick();
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int start_pop;
    rst_n   = 1'b0;
    i_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #3;
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_sum", 64'(o_sum), 64'(0));
    check("rst_flags", 64'({o_cout, o_ovf, o_zero, o_P, o_G}), 64'(0));
    check("rst_ready", 64'(o_ready), 64'(1));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_rst_ready", 64'(o_ready), 64'(1));

    directed("add", 32'h3, 32'hC, 1'b0, 1'b0, 32'h0000_000F, 3'b000);
    check("add_p0", 64'(o_P[0]), 64'(1));
    check("add_g0", 64'(o_G[0]), 64'(0));
    directed("sub57", 32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFF_FFFE, 3'b000);
    directed("sub77", 32'd7, 32'd7, 1'b1, 1'b0, 32'h0000_0000, 3'b101);
    directed("sub57_bin", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFD, 3'b000);
    directed("ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 3'b010);
    directed("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 3'b101);
    directed("cin_add", 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 3'b000);

    // Backpressure: three back-to-back beats against a stalled sink
    i_ready = 1'b0;
    start_pop = popped;
    drive(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0);
    check("bp_ready_third", 64'(o_ready), 64'(0));
    check("bp_inflight", 64'(q.size()), 64'(2));
    tick();
    tick();
    tick();
    i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("bp_results", 64'(popped - start_pop), 64'(3));

    // Reset with two beats in flight
    i_ready = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hCAFE_F00D, 32'h0BAD_F00D, 1'b1, 1'b1);
    tick();
    i_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(o_valid), 64'(0));
    check("midrst_sum", 64'(o_sum), 64'(0));
    check("midrst_ready", 64'(o_ready), 64'(1));
    q.delete();
    stall_prev = 1'b0;
    tick();
    tick();
    rst_n   = 1'b1;
    i_ready = 1'b1;
    check("midrst_release_ready", 64'(o_ready), 64'(1));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_no_stale", 64'(o_valid), 64'(0));
    end
    directed("after_rst", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 3'b000);

    // Randomized traffic with random valid/ready
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), pick_operand(), pick_operand(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      i_ready = 1'($urandom_range(0, 2) != 0);
      tick();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    check("drain_empty", 64'(q.size()), 64'(0));
    tick();
    check("drain_idle", 64'(o_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit reached");
  end

endmodule
